// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Write-port controller for the 32x32 register file. After reset it sweeps
//   R0..R31 to zero (the storage itself has no reset), then shares the single
//   write port between two writeback requesters with round-robin arbitration.
//   Writes addressed to R0 are accepted but never reach the file.
//
// Ports
//   Clk        system clock, rising edge
//   Rst        synchronous active-high reset
//   A_Valid    requester A (ALU writeback) has a write pending
//   A_RW/A_DS  requester A destination register / data
//   A_Ready    requester A accepted this cycle (combinational)
//   B_Valid    requester B (load writeback) has a write pending
//   B_RW/B_DS  requester B destination register / data
//   B_Ready    requester B accepted this cycle (combinational)
//   PW_DS      register file write data (registered)
//   RW         register file write address (registered)
//   E          register file write enable (registered)
//   Init_Done  zero sweep complete, held until the next reset
module regfile_wb_arbiter (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        A_Valid,
    input  logic [4:0]  A_RW,
    input  logic [31:0] A_DS,
    output logic        A_Ready,
    input  logic        B_Valid,
    input  logic [4:0]  B_RW,
    input  logic [31:0] B_DS,
    output logic        B_Ready,
    output logic [31:0] PW_DS,
    output logic [4:0]  RW,
    output logic        E,
    output logic        Init_Done
);

    typedef enum logic {S_INIT, S_RUN} state_t;
    typedef enum logic {PRIO_A, PRIO_B} prio_t;

    state_t     r_state;
    prio_t      r_prio;
    logic [4:0] r_cnt;
    logic       w_run;

    assign w_run = (r_state == S_RUN);

    // Ready already includes Valid, so Ready alone marks a transfer.
    assign A_Ready = w_run & A_Valid & (~B_Valid | (r_prio == PRIO_A));
    assign B_Ready = w_run & B_Valid & (~A_Valid | (r_prio == PRIO_B));

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state   <= S_INIT;
            r_cnt     <= '0;
            r_prio    <= PRIO_A;
            E         <= 1'b0;
            RW        <= '0;
            PW_DS     <= '0;
            Init_Done <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    E     <= 1'b1;
                    RW    <= r_cnt;
                    PW_DS <= '0;
                    // Counter parks at 31; leaving INIT is what ends the sweep.
                    if (r_cnt == 5'd31) begin
                        r_state   <= S_RUN;
                        Init_Done <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                S_RUN: begin
                    E <= 1'b0;
                    if (A_Ready) begin
                        // R0 transfers complete the handshake but never write.
                        E      <= (A_RW != 5'd0);
                        RW     <= A_RW;
                        PW_DS  <= A_DS;
                        r_prio <= PRIO_B;
                    end else if (B_Ready) begin
                        E      <= (B_RW != 5'd0);
                        RW     <= B_RW;
                        PW_DS  <= B_DS;
                        r_prio <= PRIO_A;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        A_Valid = 1'b0;
    logic [4:0]  A_RW = '0;
    logic [31:0] A_DS = '0;
    logic        A_Ready;
    logic        B_Valid = 1'b0;
    logic [4:0]  B_RW = '0;
    logic [31:0] B_DS = '0;
    logic        B_Ready;
    logic [31:0] PW_DS;
    logic [4:0]  RW;
    logic        E;
    logic        Init_Done;

    regfile_wb_arbiter dut (
        .Clk(Clk), .Rst(Rst),
        .A_Valid(A_Valid), .A_RW(A_RW), .A_DS(A_DS), .A_Ready(A_Ready),
        .B_Valid(B_Valid), .B_RW(B_RW), .B_DS(B_DS), .B_Ready(B_Ready),
        .PW_DS(PW_DS), .RW(RW), .E(E), .Init_Done(Init_Done)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        int unsigned stamp;
        logic [4:0]  rw;
        logic [31:0] ds;
    } wr_t;

    typedef struct {
        logic [4:0]  rw;
        logic [31:0] ds;
    } req_t;

    wr_t  exp_q[$];
    req_t qa[$];
    req_t qb[$];

    int unsigned edge_no = 0;
    int          vectors = 0;
    int          errors  = 0;
    bit          mon_en  = 0;

    // Reference model: sweep position, run/done flags, and which requester
    // lost the last tie-break (the one served last yields the next tie).
    bit m_run   = 0;
    bit m_done  = 0;
    bit m_prioB = 0;
    int m_cnt   = 0;

    bit a_act = 0;
    bit b_act = 0;
    int pa = 100;
    int pb = 100;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at edge %0d: got %h want %h", name, edge_no, act, req);
        end
    endtask

    // Monitor: pops the expected write for the edge just taken, if any.
    always @(negedge Clk) begin
        if (mon_en) begin
            bit  want;
            wr_t w;
            while (exp_q.size() != 0 && exp_q[0].stamp + 1 < edge_no) begin
                w = exp_q.pop_front();
                vectors++;
                errors++;
                $display("FAIL stale write: rw %0d data %h never appeared", w.rw, w.ds);
            end
            want = (exp_q.size() != 0) && (exp_q[0].stamp + 1 == edge_no);
            chk("E", {31'b0, E}, {31'b0, want});
            if (want) begin
                w = exp_q.pop_front();
                if (E === 1'b1) begin
                    chk("RW", {27'b0, RW}, {27'b0, w.rw});
                    chk("PW_DS", PW_DS, w.ds);
                end
            end
        end
    end

    task automatic step(input bit rst);
        bit   ga;
        bit   gb;
        req_t fa;
        req_t fb;
        wr_t  w;
        Rst = rst;
        if (!a_act && qa.size() != 0 && $urandom_range(99) < pa) a_act = 1;
        if (!b_act && qb.size() != 0 && $urandom_range(99) < pb) b_act = 1;
        A_Valid = a_act;
        B_Valid = b_act;
        if (a_act) begin fa = qa[0]; A_RW = fa.rw; A_DS = fa.ds; end
        else begin A_RW = 5'($urandom); A_DS = $urandom; end
        if (b_act) begin fb = qb[0]; B_RW = fb.rw; B_DS = fb.ds; end
        else begin B_RW = 5'($urandom); B_DS = $urandom; end
        #1;
        ga = m_run && a_act && (!b_act || !m_prioB);
        gb = m_run && b_act && (!a_act || m_prioB);
        if (mon_en) begin
            chk("A_Ready", {31'b0, A_Ready}, {31'b0, ga});
            chk("B_Ready", {31'b0, B_Ready}, {31'b0, gb});
            chk("Init_Done", {31'b0, Init_Done}, {31'b0, m_done});
        end
        @(posedge Clk);
        if (rst) begin
            m_run = 0; m_done = 0; m_cnt = 0; m_prioB = 0;
        end else if (!m_run) begin
            w.stamp = edge_no; w.rw = 5'(m_cnt); w.ds = '0;
            exp_q.push_back(w);
            m_cnt++;
            if (m_cnt == 32) begin m_run = 1; m_done = 1; end
        end else if (ga) begin
            if (fa.rw != 0) begin w.stamp = edge_no; w.rw = fa.rw; w.ds = fa.ds; exp_q.push_back(w); end
            m_prioB = 1;
            void'(qa.pop_front());
            a_act = 0;
        end else if (gb) begin
            if (fb.rw != 0) begin w.stamp = edge_no; w.rw = fb.rw; w.ds = fb.ds; exp_q.push_back(w); end
            m_prioB = 0;
            void'(qb.pop_front());
            b_act = 0;
        end
        edge_no++;
        if (rst) mon_en = 1;
        @(negedge Clk);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1);
    endtask

    task automatic drain(input int budget);
        int left;
        left = budget;
        while ((qa.size() != 0 || qb.size() != 0 || a_act || b_act) && left > 0) begin
            step(0);
            left--;
        end
        if (qa.size() != 0 || qb.size() != 0) begin
            vectors++;
            errors++;
            $display("FAIL drain timeout: %0d A and %0d B requests left", qa.size(), qb.size());
        end
        run(2);
    endtask

    task automatic push_a(input logic [4:0] rw, input logic [31:0] ds);
        req_t r; r.rw = rw; r.ds = ds; qa.push_back(r);
    endtask

    task automatic push_b(input logic [4:0] rw, input logic [31:0] ds);
        req_t r; r.rw = rw; r.ds = ds; qb.push_back(r);
    endtask

    initial begin
        // Init sweep with idle requesters
        do_reset(2);
        run(36);

        // Contention straight after reset: A wins first, then alternate
        for (int i = 0; i < 6; i++) begin
            push_a(5'd3, 32'h11);
            push_b(5'd4, 32'h22);
        end
        drain(40);

        // Single requester
        push_a(5'd5, 32'hDEADBEEF);
        drain(10);

        // R0 drop, then a tie that A should win
        push_b(5'd0, 32'hFFFFFFFF);
        drain(10);
        push_a(5'd7, 32'hA7A7A7A7);
        push_b(5'd8, 32'hB8B8B8B8);
        drain(10);

        // Reset mid-sweep
        do_reset(1);
        run(10);
        do_reset(1);
        run(36);

        // Handshake hold across the whole sweep
        do_reset(1);
        push_a(5'd9, 32'h0BADF00D);
        run(1);
        drain(60);

        // Randomized traffic
        pa = 55;
        pb = 45;
        for (int i = 0; i < 150; i++) begin
            push_a(5'($urandom), $urandom);
            push_b(5'($urandom), $urandom);
        end
        drain(2000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the 32x32 register file. After reset it sweeps all 32 registers to zero, because the register file storage has no reset. It then shares the file's single write port (PW_DS, RW, E) between two writeback requesters, port A (ALU writeback) and port B (memory-load writeback), using valid/ready handshakes and round-robin arbitration. Writes to register 0 are absorbed, which keeps R0 hard-wired to zero.

## Interface
Parameters:
- none. Width 32 and depth 32 are fixed by the register file.

Ports:
- Clk  in  1  system clock; all state updates on the rising edge
- Rst  in  1  reset, synchronous, active-high
- A_Valid  in  1  requester A has a write pending
- A_RW  in  5  requester A destination register
- A_DS  in  32  requester A write data
- A_Ready  out  1  requester A write accepted this cycle (combinational)
- B_Valid  in  1  requester B has a write pending
- B_RW  in  5  requester B destination register
- B_DS  in  32  requester B write data
- B_Ready  out  1  requester B write accepted this cycle (combinational)
- PW_DS  out  32  register file write data (registered)
- RW  out  5  register file write address (registered)
- E  out  1  register file write enable (registered)
- Init_Done  out  1  zero sweep complete; stays high until the next reset

## Operation
- State machine with two states:
  - INIT: a 5-bit sweep counter cnt drives the write port.
  - RUN: the block arbitrates between requesters.
- Reset, when Rst=1 at a rising edge:
  - state←INIT, cnt←0, prio←A.
  - E←0, RW←0, PW_DS←0, Init_Done←0.
- INIT, one register per edge:
  - each edge loads E←1, RW←cnt, PW_DS←0, then cnt←cnt+1.
  - On the edge that issues RW=31: state←RUN, Init_Done←1. The counter does not wrap back into another sweep.
  - A_Ready=B_Ready=0 throughout INIT.
- RUN arbitration:
  - A_Ready = A_Valid & (!B_Valid | prio==A).
  - B_Ready = B_Valid & (!A_Valid | prio==B).
  - At most one Ready is high per cycle.
- Transfer: a transfer occurs when Valid&Ready is high at a rising edge.
  - That edge loads E←1, RW←x_RW, PW_DS←x_DS.
  - prio then flips to the other requester (the last-served requester loses the next tie).
- No transfer in RUN: E←0. RW and PW_DS hold their previous values.
- R0 writes:
  - A transfer with x_RW=0 is accepted (Ready asserted, prio flips), but E←0.
  - R0 is written only by the INIT sweep.
- Requester rules:
  - Valid must not depend combinationally on Ready.
  - Once Valid is asserted, Valid, x_RW and x_DS stay stable until the transfer completes.
  - Ready may depend combinationally on both Valid inputs.

## Timing
- Write latency: the transfer happens at edge N; E/RW/PW_DS are presented during cycle N..N+1; the register file captures at edge N+1, so the data is readable on PA/PB after edge N+1.
- INIT duration: 32 cycles after the first edge with Rst=0.
  - R31 is captured at the 33rd edge.
  - Init_Done rises at the 32nd edge, together with the RW=31 issue.
  - The first RUN transfer may occur at the 33rd edge. There is no conflict, because each edge carries exactly one write.
- Throughput: one accepted write per cycle. Under continuous contention A and B alternate, so each requester waits at most 1 cycle.
- Reset mid-sweep or mid-RUN: the next edge applies the reset values.
  - Any write already presented on E is still captured by the register file at that same edge.
  - No further writes are issued until the sweep restarts from R0.
- Simultaneous Valid with equal x_RW: only the granted requester writes this cycle; the other writes the next cycle, so the later write wins.

## Test plan
- Init sweep: pulse Rst for 2 cycles, then hold requesters idle → E=1 for 32 consecutive cycles with RW=0..31 and PW_DS=0; Init_Done rises with RW=31; E=0 afterwards; all PA/PB reads return 0.
- Single requester: after init, A_Valid with A_RW=5, A_DS=0xDEADBEEF for 1 cycle → A_Ready=1, next cycle E=1, RW=5, PW_DS=0xDEADBEEF; PA with RA=5 reads 0xDEADBEEF one edge later.
- Contention: A and B valid continuously, A_RW=3/A_DS=0x11, B_RW=4/B_DS=0x22 → grants alternate A,B,A,B starting with A; E is never low; Ready is never high on both ports.
- R0 drop: B_Valid with B_RW=0, B_DS=0xFFFFFFFF → B_Ready=1, E stays 0, R0 still reads 0, and prio moves to A.
- Reset mid-sweep: assert Rst at sweep cycle 10 for 1 cycle → the sweep restarts at RW=0, Init_Done stays 0 until the full 32-write sweep completes.
- Handshake hold: A_Valid is asserted throughout the INIT sweep → A_Ready=0 for the whole sweep; the transfer completes at the first RUN opportunity with the original data.
